// File: rtl/npuarc_biu_ibp_outstand_pkg.sv
// npuarc_biu_ibp_outstand_pkg: drain FSM states and counter width helper
package npuarc_biu_ibp_outstand_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/npuarc_biu_ibp_outstand_cnt.sv
// npuarc_biu_ibp_outstand_cnt: saturating-at-zero up/down outstanding counter with sticky underflow flag
module npuarc_biu_ibp_outstand_cnt #(
    parameter int MAX = 16,
    parameter int W   = 5
) (
    input  logic         clk,
    input  logic         rst_a,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         full_o,
    output logic         zero_o,
    output logic         err_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         err_q, err_d;

    assign zero_o = cnt_q == '0;
    assign full_o = cnt_q == W'(MAX);
    assign cnt_o  = cnt_q;
    assign err_o  = err_q;

    // a retire with nothing outstanding holds at zero and flags the error
    always_comb begin
        cnt_d = (inc_i & ~dec_i) ? cnt_q + W'(1) :
                (dec_i & ~inc_i & ~zero_o) ? cnt_q - W'(1) : cnt_q;
        err_d = err_q | (dec_i & ~inc_i & zero_o);
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/npuarc_biu_ibp_outstand_ctrl.sv
// npuarc_biu_ibp_outstand_ctrl: per-port IBP outstanding read/write tracking, accept throttling
// and a drain handshake that blocks new commands until every port is idle.
module npuarc_biu_ibp_outstand_ctrl
    import npuarc_biu_ibp_outstand_pkg::*;
#(
    parameter int  NUM_PORTS  = 2,
    parameter int  RD_OUT_MAX = 16,
    parameter int  WR_OUT_MAX = 16,
    localparam int CNT_W = clog2(((RD_OUT_MAX > WR_OUT_MAX) ? RD_OUT_MAX : WR_OUT_MAX) + 1)
) (
    input  logic                         clk,
    input  logic                         rst_a,
    input  logic                         nmi_restart_r,
    input  logic [NUM_PORTS-1:0]         cmd_valid,
    input  logic [NUM_PORTS-1:0]         cmd_read,
    input  logic [NUM_PORTS-1:0]         cmd_accept_in,
    output logic [NUM_PORTS-1:0]         cmd_accept_out,
    input  logic [NUM_PORTS-1:0]         rd_valid,
    input  logic [NUM_PORTS-1:0]         rd_accept,
    input  logic [NUM_PORTS-1:0]         rd_last,
    input  logic [NUM_PORTS-1:0]         wrsp_valid,
    input  logic [NUM_PORTS-1:0]         wrsp_accept,
    input  logic                         drain_req,
    output logic                         drain_ack,
    output logic [NUM_PORTS-1:0]         port_idle,
    output logic                         all_idle,
    output logic [NUM_PORTS*CNT_W-1:0]   rd_cnt,
    output logic [NUM_PORTS*CNT_W-1:0]   wr_cnt,
    output logic [NUM_PORTS-1:0]         cnt_err
);

    state_t               state_q, state_d;
    logic                 draining;
    logic [NUM_PORTS-1:0] blk, rd_inc, wr_inc, rd_dec, wr_dec;
    logic [NUM_PORTS-1:0] rd_full, wr_full, rd_zero, wr_zero, rd_err, wr_err;

    // limits use registered counts only, so a same-cycle retire unblocks one cycle later
    assign draining       = state_q != IDLE;
    assign blk            = {NUM_PORTS{draining}} | (cmd_read & rd_full) | (~cmd_read & wr_full);
    assign cmd_accept_out = cmd_accept_in & ~blk;
    assign rd_inc         = cmd_valid & cmd_accept_out & cmd_read;
    assign wr_inc         = cmd_valid & cmd_accept_out & ~cmd_read;
    assign rd_dec         = rd_valid & rd_accept & rd_last;
    assign wr_dec         = wrsp_valid & wrsp_accept;
    assign port_idle      = rd_zero & wr_zero;
    assign all_idle       = &port_idle;
    assign cnt_err        = rd_err | wr_err;
    assign drain_ack      = state_q == DONE;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        npuarc_biu_ibp_outstand_cnt #(.MAX(RD_OUT_MAX), .W(CNT_W)) u_rd (
            .clk    (clk),
            .rst_a  (rst_a),
            .clr_i  (nmi_restart_r),
            .inc_i  (rd_inc[p]),
            .dec_i  (rd_dec[p]),
            .cnt_o  (rd_cnt[p*CNT_W +: CNT_W]),
            .full_o (rd_full[p]),
            .zero_o (rd_zero[p]),
            .err_o  (rd_err[p])
        );
        npuarc_biu_ibp_outstand_cnt #(.MAX(WR_OUT_MAX), .W(CNT_W)) u_wr (
            .clk    (clk),
            .rst_a  (rst_a),
            .clr_i  (nmi_restart_r),
            .inc_i  (wr_inc[p]),
            .dec_i  (wr_dec[p]),
            .cnt_o  (wr_cnt[p*CNT_W +: CNT_W]),
            .full_o (wr_full[p]),
            .zero_o (wr_zero[p]),
            .err_o  (wr_err[p])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = drain_req ? DRAIN : IDLE;
            DRAIN:   state_d = ~drain_req ? IDLE : (all_idle ? DONE : DRAIN);
            DONE:    state_d = drain_req ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        if (nmi_restart_r) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) state_q <= IDLE;
        else       state_q <= state_d;
    end

endmodule

// File: tb/tb_npuarc_biu_ibp_outstand_ctrl.sv
// tb_npuarc_biu_ibp_outstand_ctrl: scenario tasks with a cycle model feeding an expected-value queue
module tb_npuarc_biu_ibp_outstand_ctrl;

    localparam int NP = 2;
    localparam int W  = 5;
    localparam int MX = 16;

    logic            clk = 1'b0;
    logic            rst_a, nmi_restart_r, drain_req;
    logic [NP-1:0]   cmd_valid, cmd_read, cmd_accept_in, cmd_accept_out;
    logic [NP-1:0]   rd_valid, rd_accept, rd_last, wrsp_valid, wrsp_accept;
    logic            drain_ack, all_idle;
    logic [NP-1:0]   port_idle, cnt_err;
    logic [NP*W-1:0] rd_cnt, wr_cnt;

    typedef struct {
        logic [NP*W-1:0] rd;
        logic [NP*W-1:0] wr;
        logic [NP-1:0]   err;
        logic            ack;
        logic [NP-1:0]   idle;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   m_rd[NP], m_wr[NP], m_st;
    bit   m_err[NP];
    int   n_chk = 0, n_fail = 0;

    npuarc_biu_ibp_outstand_ctrl #(.NUM_PORTS(NP), .RD_OUT_MAX(MX), .WR_OUT_MAX(MX)) dut (
        .clk            (clk),
        .rst_a          (rst_a),
        .nmi_restart_r  (nmi_restart_r),
        .cmd_valid      (cmd_valid),
        .cmd_read       (cmd_read),
        .cmd_accept_in  (cmd_accept_in),
        .cmd_accept_out (cmd_accept_out),
        .rd_valid       (rd_valid),
        .rd_accept      (rd_accept),
        .rd_last        (rd_last),
        .wrsp_valid     (wrsp_valid),
        .wrsp_accept    (wrsp_accept),
        .drain_req      (drain_req),
        .drain_ack      (drain_ack),
        .port_idle      (port_idle),
        .all_idle       (all_idle),
        .rd_cnt         (rd_cnt),
        .wr_cnt         (wr_cnt),
        .cnt_err        (cnt_err)
    );

    always #5 clk = ~clk;

    // advance the reference model by one clock from the current inputs and queue its outputs
    task automatic model_push();
        bit   idle_all, blk, acc, ri, wi, rdd, wd;
        exp_t x;
        idle_all = 1;
        for (int p = 0; p < NP; p++) if (m_rd[p] != 0 || m_wr[p] != 0) idle_all = 0;
        for (int p = 0; p < NP; p++) begin
            blk = (m_st != 0) || (cmd_read[p] ? m_rd[p] == MX : m_wr[p] == MX);
            acc = cmd_accept_in[p] && !blk;
            ri  = cmd_valid[p] && acc && cmd_read[p];
            wi  = cmd_valid[p] && acc && !cmd_read[p];
            rdd = rd_valid[p] && rd_accept[p] && rd_last[p];
            wd  = wrsp_valid[p] && wrsp_accept[p];
            if (ri && !rdd) m_rd[p]++;
            else if (rdd && !ri) begin
                if (m_rd[p] == 0) m_err[p] = 1; else m_rd[p]--;
            end
            if (wi && !wd) m_wr[p]++;
            else if (wd && !wi) begin
                if (m_wr[p] == 0) m_err[p] = 1; else m_wr[p]--;
            end
        end
        case (m_st)
            0: m_st = drain_req ? 1 : 0;
            1: m_st = !drain_req ? 0 : (idle_all ? 2 : 1);
            default: m_st = drain_req ? 2 : 0;
        endcase
        if (nmi_restart_r) begin
            m_st = 0;
            for (int p = 0; p < NP; p++) begin
                m_rd[p] = 0; m_wr[p] = 0; m_err[p] = 0;
            end
        end
        for (int p = 0; p < NP; p++) begin
            x.rd[p*W +: W] = W'(m_rd[p]);
            x.wr[p*W +: W] = W'(m_wr[p]);
            x.err[p]       = m_err[p];
            x.idle[p]      = m_rd[p] == 0 && m_wr[p] == 0;
        end
        x.ack = m_st == 2;
        sb.push_back(x);
    endtask

    task automatic cycle();
        model_push();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1; nmi_restart_r = 0; drain_req = 0;
        cmd_valid = 0; cmd_read = 0; cmd_accept_in = 0;
        rd_valid = 0; rd_accept = 0; rd_last = 0; wrsp_valid = 0; wrsp_accept = 0;
        for (int p = 0; p < NP; p++) begin
            m_rd[p] = 0; m_wr[p] = 0; m_err[p] = 0;
        end
        m_st = 0;
        repeat (2) @(posedge clk);
        #1 rst_a = 0;
        n_chk++; if (rd_cnt !== '0) begin n_fail++; $display("FAIL reset_rd_cnt got %h exp 0", rd_cnt); end
        n_chk++; if (wr_cnt !== '0) begin n_fail++; $display("FAIL reset_wr_cnt got %h exp 0", wr_cnt); end
        n_chk++; if (cnt_err !== 2'b00) begin n_fail++; $display("FAIL reset_cnt_err got %b exp 00", cnt_err); end
        n_chk++; if (drain_ack !== 1'b0) begin n_fail++; $display("FAIL reset_drain_ack got %b exp 0", drain_ack); end
        n_chk++; if ({port_idle, all_idle} !== 3'b111) begin n_fail++; $display("FAIL reset_idle got %b exp 111", {port_idle, all_idle}); end
    endtask

    task automatic test_rd_limit();
        cmd_accept_in = 2'b11; rd_accept = 2'b11; rd_last = 2'b11; wrsp_accept = 2'b11;
        cmd_valid[0] = 1; cmd_read[0] = 1;
        for (int i = 0; i < MX; i++) begin
            cycle();
            e = sb.pop_front(); n_chk++;
            if ({rd_cnt, wr_cnt, cnt_err, drain_ack, port_idle} !== {e.rd, e.wr, e.err, e.ack, e.idle}) begin
                n_fail++; $display("FAIL rd_limit cyc %0d got %h exp %h", i, {rd_cnt, wr_cnt, cnt_err, drain_ack, port_idle}, {e.rd, e.wr, e.err, e.ack, e.idle});
            end
        end
        n_chk++; if (rd_cnt[W-1:0] !== 5'd16) begin n_fail++; $display("FAIL rd_full_cnt got %0d exp 16", rd_cnt[W-1:0]); end
        n_chk++; if (cmd_accept_out[0] !== 1'b0) begin n_fail++; $display("FAIL rd_17th_blocked got %b exp 0", cmd_accept_out[0]); end
        cmd_read[0] = 0;
        #1;
        n_chk++; if (cmd_accept_out[0] !== 1'b1) begin n_fail++; $display("FAIL wr_while_rd_full got %b exp 1", cmd_accept_out[0]); end
        cycle();
        e = sb.pop_front(); n_chk++;
        if ({rd_cnt, wr_cnt, cnt_err, port_idle} !== {e.rd, e.wr, e.err, e.idle}) begin
            n_fail++; $display("FAIL wr_at_rd_full got %h exp %h", {rd_cnt, wr_cnt, cnt_err, port_idle}, {e.rd, e.wr, e.err, e.idle});
        end
        cmd_valid[0] = 0;
    endtask

    task automatic test_retire_same_cycle();
        cmd_valid[0] = 1; cmd_read[0] = 1; rd_valid[0] = 1;
        #1;
        n_chk++; if (cmd_accept_out[0] !== 1'b0) begin n_fail++; $display("FAIL retire_same_blocked got %b exp 0", cmd_accept_out[0]); end
        cycle();
        e = sb.pop_front(); n_chk++;
        if (rd_cnt !== e.rd || rd_cnt[W-1:0] !== 5'd15) begin n_fail++; $display("FAIL retire_to_15 got %h exp %h", rd_cnt, e.rd); end
        rd_valid[0] = 0;
        #1;
        n_chk++; if (cmd_accept_out[0] !== 1'b1) begin n_fail++; $display("FAIL retire_next_accept got %b exp 1", cmd_accept_out[0]); end
        cycle();
        e = sb.pop_front(); n_chk++;
        if (rd_cnt !== e.rd || rd_cnt[W-1:0] !== 5'd16) begin n_fail++; $display("FAIL refill_to_16 got %h exp %h", rd_cnt, e.rd); end
        cmd_valid[0] = 0; rd_valid[0] = 1; wrsp_valid[0] = 1;
        for (int i = 0; i < MX; i++) begin
            cycle();
            wrsp_valid[0] = 0;
            e = sb.pop_front(); n_chk++;
            if ({rd_cnt, wr_cnt, cnt_err, port_idle} !== {e.rd, e.wr, e.err, e.idle}) begin
                n_fail++; $display("FAIL rd_retire cyc %0d got %h exp %h", i, {rd_cnt, wr_cnt, cnt_err, port_idle}, {e.rd, e.wr, e.err, e.idle});
            end
        end
        rd_valid[0] = 0;
    endtask

    task automatic test_wr_same_cycle();
        cmd_valid[1] = 1; cmd_read[1] = 0;
        repeat (3) cycle();
        repeat (3) void'(sb.pop_front());
        wrsp_valid[1] = 1;
        cycle();
        e = sb.pop_front(); n_chk++;
        if (wr_cnt !== e.wr || wr_cnt[2*W-1:W] !== 5'd3) begin n_fail++; $display("FAIL wr_inc_dec_hold got %h exp %h", wr_cnt, e.wr); end
        n_chk++; if (port_idle[1] !== 1'b0) begin n_fail++; $display("FAIL wr_hold_not_idle got %b exp 0", port_idle[1]); end
        cmd_valid[1] = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            e = sb.pop_front(); n_chk++;
            if ({wr_cnt, port_idle, cnt_err} !== {e.wr, e.idle, e.err}) begin
                n_fail++; $display("FAIL wr_retire cyc %0d got %h exp %h", i, {wr_cnt, port_idle, cnt_err}, {e.wr, e.idle, e.err});
            end
        end
        wrsp_valid[1] = 0;
    endtask

    task automatic test_underflow();
        wrsp_valid[0] = 1;
        cycle();
        wrsp_valid[0] = 0;
        e = sb.pop_front(); n_chk++;
        if ({wr_cnt, cnt_err} !== {e.wr, e.err} || cnt_err[0] !== 1'b1) begin
            n_fail++; $display("FAIL underflow got %h exp %h", {wr_cnt, cnt_err}, {e.wr, e.err});
        end
        repeat (3) cycle();
        repeat (3) void'(sb.pop_front());
        n_chk++; if (cnt_err[0] !== 1'b1 || wr_cnt[W-1:0] !== 5'd0) begin n_fail++; $display("FAIL underflow_sticky got err %b wr %0d exp err 1 wr 0", cnt_err[0], wr_cnt[W-1:0]); end
    endtask

    task automatic test_drain();
        cmd_valid = 2'b01; cmd_read = 2'b01;
        repeat (2) cycle();
        cmd_valid = 2'b10; cmd_read = 2'b00;
        cycle();
        cmd_valid = 2'b00;
        repeat (3) void'(sb.pop_front());
        drain_req = 1;
        #1;
        n_chk++; if (cmd_accept_out !== 2'b11) begin n_fail++; $display("FAIL drain_same_cycle_accept got %b exp 11", cmd_accept_out); end
        cycle(); void'(sb.pop_front());
        n_chk++; if (cmd_accept_out !== 2'b00) begin n_fail++; $display("FAIL drain_blocks got %b exp 00", cmd_accept_out); end
        cmd_valid = 2'b11; cmd_read = 2'b01;
        rd_valid[0] = 1; wrsp_valid[1] = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            cmd_valid = 2'b00; wrsp_valid[1] = 0;
            if (i == 1) rd_valid[0] = 0;
            e = sb.pop_front(); n_chk++;
            if ({rd_cnt, wr_cnt, cnt_err, drain_ack, port_idle} !== {e.rd, e.wr, e.err, e.ack, e.idle}) begin
                n_fail++; $display("FAIL drain cyc %0d got %h exp %h", i, {rd_cnt, wr_cnt, cnt_err, drain_ack, port_idle}, {e.rd, e.wr, e.err, e.ack, e.idle});
            end
        end
        n_chk++; if (drain_ack !== 1'b1 || all_idle !== 1'b1) begin n_fail++; $display("FAIL drain_ack got ack %b idle %b exp 1 1", drain_ack, all_idle); end
        drain_req = 0;
        cycle(); void'(sb.pop_front());
        n_chk++; if (drain_ack !== 1'b0 || cmd_accept_out !== 2'b11) begin n_fail++; $display("FAIL drain_release got ack %b acc %b exp 0 11", drain_ack, cmd_accept_out); end
    endtask

    task automatic test_nmi();
        cmd_valid = 2'b01; cmd_read = 2'b01;
        repeat (5) cycle();
        cmd_valid = 2'b00; drain_req = 1;
        cycle();
        repeat (6) void'(sb.pop_front());
        n_chk++; if (rd_cnt[W-1:0] !== 5'd5 || cmd_accept_out !== 2'b00) begin n_fail++; $display("FAIL nmi_pre got rd %0d acc %b exp 5 00", rd_cnt[W-1:0], cmd_accept_out); end
        nmi_restart_r = 1; cmd_valid = 2'b11; rd_valid[0] = 1;
        cycle();
        nmi_restart_r = 0; cmd_valid = 2'b00; rd_valid[0] = 0;
        e = sb.pop_front(); n_chk++;
        if ({rd_cnt, wr_cnt, cnt_err, drain_ack, port_idle} !== {e.rd, e.wr, e.err, e.ack, e.idle}) begin
            n_fail++; $display("FAIL nmi_model got %h exp %h", {rd_cnt, wr_cnt, cnt_err, drain_ack, port_idle}, {e.rd, e.wr, e.err, e.ack, e.idle});
        end
        n_chk++; if ({rd_cnt, wr_cnt, cnt_err} !== '0 || drain_ack !== 1'b0 || all_idle !== 1'b1) begin
            n_fail++; $display("FAIL nmi_clear got rd %h wr %h err %b ack %b idle %b exp all clear", rd_cnt, wr_cnt, cnt_err, drain_ack, all_idle);
        end
        n_chk++; if (cmd_accept_out !== 2'b11) begin n_fail++; $display("FAIL nmi_fsm_idle got %b exp 11", cmd_accept_out); end
        drain_req = 0;
        cycle(); void'(sb.pop_front());
    endtask

    initial begin
        test_reset();
        test_rd_limit();
        test_retire_same_cycle();
        test_wr_same_cycle();
        test_underflow();
        test_drain();
        test_nmi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
